matmul_ctrl: RTL and testbench
==============================

Name: matmul_ctrl

Overview:
- Sequencer for the MAX_DIM x MAX_DIM matrix-multiply PE array.
- Accepts a job (dimensions N, K, M) and clears the accumulators.
- Steps K operand feeds into the array, then flushes the systolic skew.
- Streams the N*M results to the result buffer with a valid/ready handshake, then signals completion.
- Sits between the register/bus front end and the PE array and operand/result buffers; holds no matrix data itself.

Parameters:
- DATA_WIDTH, 32, operand element width; used only for the MAX_DIM derivation.
- BUS_WIDTH, 64, bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (default 2).
- DIM_W, $clog2(MAX_DIM+1), width of dimension fields (default 2).
- IDX_W, max(1,$clog2(MAX_DIM)), width of row/col/step indices (default 1).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  job request, sampled only in IDLE.
- n_dim_i  in  DIM_W  rows of A.
- k_dim_i  in  DIM_W  cols of A / rows of B.
- m_dim_i  in  DIM_W  cols of B.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse: start with illegal dimensions.
- pe_clr_o  out  1  clear all PE accumulators.
- pe_en_o  out  1  advance array one step (FEED and DRAIN).
- feed_vld_o  out  1  operand column/row valid this step.
- feed_idx_o  out  IDX_W  k index: A column / B row to read.
- res_vld_o  out  1  result element valid.
- res_ready_i  in  1  result buffer accepts element.
- res_row_o  out  IDX_W  result row index.
- res_col_o  out  IDX_W  result column index.

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; dimensions register 0. Reset in any state aborts the job in the same cycle with no done_o.
- Legal job: 1 <= N,K,M <= MAX_DIM.
- IDLE:
  - start_i with a legal job latches N, K, M and goes to CLEAR next cycle.
  - start_i with an illegal job pulses err_o next cycle and stays in IDLE.
- start_i outside IDLE is ignored, and dimension inputs are not re-sampled.
- CLEAR: 1 cycle; pe_clr_o=1; then FEED.
- FEED: K cycles; pe_en_o=1, feed_vld_o=1, feed_idx_o = 0..K-1. After the last step: DRAIN if N+M-2 > 0, else WRITEBACK.
- DRAIN: N+M-2 cycles; pe_en_o=1, feed_vld_o=0, feed_idx_o=0.
- WRITEBACK:
  - res_vld_o=1; (res_row_o,res_col_o) walks row-major (0,0),(0,1)..(N-1,M-1).
  - An index advances only on res_vld_o && res_ready_i.
  - res_vld_o, res_row_o and res_col_o stay stable while res_ready_i=0.
  - After the N*M-th accepted beat, go to DONE.
- DONE: 1 cycle; done_o=1, busy_o=1; then IDLE. A start_i in DONE is ignored.
- All outputs are registered (Moore).
- Latency with res_ready_i tied high, start accepted at cycle t:
  - CLEAR at t+1.
  - FEED at t+2 .. t+1+K.
  - done_o at t+K+N+M+N*M.
- pe_en_o is never high in CLEAR, WRITEBACK or DONE. pe_clr_o and pe_en_o are never high together.

Optional Feature:
- Macro: MATMUL_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt_o [15:0]: counts WRITEBACK cycles with res_vld_o=1 and res_ready_i=0.
  - Cleared on CLEAR entry and on reset; saturates at 16'hFFFF.
  - Holds its value after done_o until the next accepted start.
- Not defined: port absent; no counter logic.

Test Plan:
- Reset mid-job: N=K=M=2 with ready=1, assert rst_i during FEED -> next cycle state IDLE and all outputs 0. A following start completes normally.
- N=K=M=1 with ready=1, start at t:
  - pe_clr_o at t+1.
  - One feed at t+2, idx 0.
  - No DRAIN.
  - res (0,0) at t+3.
  - done_o at t+4.
- N=K=M=2 with ready=1, start at t:
  - feed_idx 0,1 at t+2,t+3.
  - DRAIN at t+4,t+5.
  - res (0,0),(0,1),(1,0),(1,1) at t+6..t+9.
  - done_o at t+10.
- Illegal dimensions: start with N=0 -> err_o one pulse, busy_o stays 0. Start with K=3 (> MAX_DIM) -> err_o pulse.
- Backpressure: N=2,K=1,M=2 with res_ready_i low for 3 cycles on beat (0,1):
  - res_row/res_col hold (0,1).
  - done_o is delayed by exactly 3 cycles.
  - With MATMUL_CTRL_PERF_EN, stall_cnt_o=3.
- Start while busy: second start_i pulse during DRAIN is ignored. Dimensions are unchanged and exactly one done_o is produced.

Source files
------------

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: job sequencer for the MAX_DIM x MAX_DIM matrix-multiply PE array.
//
// A job (N, K, M) is accepted in IDLE. The sequencer then:
//   1. clears the PE accumulators (CLEAR, 1 cycle),
//   2. steps K operand feeds into the array (FEED, K cycles),
//   3. flushes the systolic skew (DRAIN, N+M-2 cycles),
//   4. streams the N*M results row-major over a valid/ready handshake (WRITEBACK),
//   5. pulses done_o (DONE, 1 cycle).
// It holds no matrix data. All outputs are registered.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; aborts any job with no done_o
//   start_i      job request, sampled only in IDLE
//   n_dim_i      rows of A
//   k_dim_i      cols of A / rows of B
//   m_dim_i      cols of B
//   busy_o       high in every state except IDLE
//   done_o       one-cycle completion pulse
//   err_o        one-cycle pulse after a start with illegal dimensions
//   pe_clr_o     clear all PE accumulators
//   pe_en_o      advance the array one step (FEED and DRAIN)
//   feed_vld_o   operand column/row valid this step
//   feed_idx_o   k index of the A column / B row to read
//   res_vld_o    result element valid
//   res_ready_i  result buffer accepts element
//   res_row_o    result row index
//   res_col_o    result column index
//   stall_cnt_o  (only with MATMUL_CTRL_PERF_EN) WRITEBACK cycles stalled by res_ready_i=0,
//                saturating; cleared on reset and on job acceptance
//
// Optional feature macro: MATMUL_CTRL_PERF_EN.

module matmul_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int DIM_W     = $clog2(MAX_DIM + 1),
  localparam int IDX_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] n_dim_i,
  input  logic [DIM_W-1:0] k_dim_i,
  input  logic [DIM_W-1:0] m_dim_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             pe_clr_o,
  output logic             pe_en_o,
  output logic             feed_vld_o,
  output logic [IDX_W-1:0] feed_idx_o,
  output logic             res_vld_o,
  input  logic             res_ready_i,
  output logic [IDX_W-1:0] res_row_o,
  output logic [IDX_W-1:0] res_col_o
`ifdef MATMUL_CTRL_PERF_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  // Step counter is shared by FEED (max K-1) and DRAIN (max 2*MAX_DIM-3).
  localparam int CNT_W = DIM_W + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StFeed  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StWb    = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic             err_d;
  logic             legal;
  logic [CNT_W-1:0] drain_len;
  logic             beat;

  assign legal = (n_dim_i != '0) && (k_dim_i != '0) && (m_dim_i != '0) &&
                 (n_dim_i <= DIM_W'(MAX_DIM)) && (k_dim_i <= DIM_W'(MAX_DIM)) &&
                 (m_dim_i <= DIM_W'(MAX_DIM));

  // N and M are at least 1 once latched, so this never underflows.
  assign drain_len = CNT_W'(n_q) + CNT_W'(m_q) - CNT_W'(2);

  assign beat = res_vld_o && res_ready_i;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (legal) begin
            n_d     = n_dim_i;
            k_d     = k_dim_i;
            m_d     = m_dim_i;
            cnt_d   = '0;
            state_d = StClear;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (cnt_q == CNT_W'(k_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = (drain_len != '0) ? StDrain : StWb;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (cnt_q == drain_len - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWb: begin
        if (beat) begin
          if (DIM_W'(col_q) == m_q - DIM_W'(1)) begin
            col_d = '0;
            if (DIM_W'(row_q) == n_q - DIM_W'(1)) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d = row_q + IDX_W'(1);
            end
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      pe_clr_o   <= 1'b0;
      pe_en_o    <= 1'b0;
      feed_vld_o <= 1'b0;
      feed_idx_o <= '0;
      res_vld_o  <= 1'b0;
      res_row_o  <= '0;
      res_col_o  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_o     <= (state_d != StIdle);
      done_o     <= (state_d == StDone);
      err_o      <= err_d;
      pe_clr_o   <= (state_d == StClear);
      pe_en_o    <= (state_d == StFeed) || (state_d == StDrain);
      feed_vld_o <= (state_d == StFeed);
      feed_idx_o <= (state_d == StFeed) ? IDX_W'(cnt_d) : '0;
      res_vld_o  <= (state_d == StWb);
      res_row_o  <= (state_d == StWb) ? row_d : '0;
      res_col_o  <= (state_d == StWb) ? col_d : '0;
    end
  end

`ifdef MATMUL_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && (state_d == StClear)) begin
      stall_q <= '0;
    end else if ((state_q == StWb) && res_vld_o && !res_ready_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Testbench for matmul_ctrl: directed jobs checked every cycle against a schedule-level
// model (cycle offset from job acceptance plus a queue of expected result beats),
// with literal latency/beat expectations pinning the model.

module tb_matmul_ctrl;

  localparam int MAXD = 64 / 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] n_dim = '0, k_dim = '0, m_dim = '0;
  logic       res_ready = 1'b1;
  logic       busy, done, err, pe_clr, pe_en, feed_vld, res_vld;
  logic [0:0] feed_idx, res_row, res_col;
`ifdef MATMUL_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  matmul_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .n_dim_i     (n_dim),
    .k_dim_i     (k_dim),
    .m_dim_i     (m_dim),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .pe_clr_o    (pe_clr),
    .pe_en_o     (pe_en),
    .feed_vld_o  (feed_vld),
    .feed_idx_o  (feed_idx),
    .res_vld_o   (res_vld),
    .res_ready_i (res_ready),
    .res_row_o   (res_row),
    .res_col_o   (res_col)
`ifdef MATMUL_CTRL_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: job active flag, offset since acceptance (1 = clear cycle), dims,
  // remaining result beats encoded as row*16+col.
  bit m_act = 1'b0;
  bit m_err = 1'b0;
  int m_o, m_n, m_k, m_m;
  int m_stall = 0;
  int beats[$];

  always @(negedge clk) begin
    int e_busy, e_done, e_clr, e_en, e_fv, e_idx, e_rv, e_row, e_col;
    e_busy = m_act; e_done = 0; e_clr = 0; e_en = 0; e_fv = 0; e_idx = 0;
    e_rv = 0; e_row = 0; e_col = 0;
    if (m_act) begin
      if (m_o == 1) e_clr = 1;
      else if (m_o <= 1 + m_k) begin e_en = 1; e_fv = 1; e_idx = m_o - 2; end
      else if (m_o <= m_k + m_n + m_m - 1) e_en = 1;
      else if (beats.size() > 0) begin
        e_rv = 1; e_row = beats[0] / 16; e_col = beats[0] % 16;
      end else e_done = 1;
    end
    if (chk_en) begin
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("err", int'(err), int'(m_err));
      chk("pe_clr", int'(pe_clr), e_clr);
      chk("pe_en", int'(pe_en), e_en);
      chk("feed_vld", int'(feed_vld), e_fv);
      chk("feed_idx", int'(feed_idx), e_idx);
      chk("res_vld", int'(res_vld), e_rv);
      chk("res_row", int'(res_row), e_row);
      chk("res_col", int'(res_col), e_col);
`ifdef MATMUL_CTRL_PERF_EN
      chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
    end
    // Advance the model with the inputs the DUT samples at the coming edge.
    m_err = 1'b0;
    if (rst) begin
      m_act = 1'b0;
      m_stall = 0;
      beats.delete();
    end else if (!m_act) begin
      if (start) begin
        if (n_dim >= 1 && n_dim <= MAXD && k_dim >= 1 && k_dim <= MAXD &&
            m_dim >= 1 && m_dim <= MAXD) begin
          m_act = 1'b1; m_o = 1; m_n = n_dim; m_k = k_dim; m_m = m_dim; m_stall = 0;
          beats.delete();
          for (int r = 0; r < m_n; r++)
            for (int c = 0; c < m_m; c++) beats.push_back(r * 16 + c);
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      if (e_rv == 1 && res_ready) void'(beats.pop_front());
      if (e_rv == 1 && !res_ready) m_stall++;
      if (e_done == 1) m_act = 1'b0;
      else m_o++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job; ready is low for relative cycles [sf, sf+sl); a second start with
  // dims 1,1,1 is pulsed at relative cycle rs (negative = none).
  task automatic run_job(input int n, input int k, input int m, input int sf, input int sl,
                         input int rs, output int lat, output int dones, output int first_res,
                         output int feeds);
    int t, rel;
    tick();
    n_dim = 2'(n); k_dim = 2'(k); m_dim = 2'(m); start = 1'b1; res_ready = 1'b1;
    t = cyc;
    lat = -1; dones = 0; first_res = -1; feeds = 0;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      tick();
      start = 1'b0;
      rel = cyc - t;
      res_ready = !(rel >= sf && rel < sf + sl);
      if (rel == rs) begin
        start = 1'b1; n_dim = 2'd1; k_dim = 2'd1; m_dim = 2'd1;
      end
      if (feed_vld) feeds++;
      if (res_vld && first_res < 0) first_res = rel;
      if (done) begin lat = rel; dones++; end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    res_ready = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
  endtask

  initial begin
    int t, lat, dones, fr, feeds;
    tick();
    chk_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    tick();
    rst = 1'b0;

    // Reset during FEED aborts the job.
    tick();
    n_dim = 2'd2; k_dim = 2'd2; m_dim = 2'd2; start = 1'b1; t = cyc;
    tick(); start = 1'b0;
    chk("mid_clr", int'(pe_clr), 1);
    tick(); rst = 1'b1;
    chk("mid_feed", int'(feed_vld), 1);
    tick(); rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(pe_en), 0);
    chk("rst_feed", int'(feed_vld), 0);

    run_job(2, 2, 2, -1, 0, -1, lat, dones, fr, feeds);
    chk("after_rst_lat", lat, 10);
    chk("after_rst_dones", dones, 1);

    run_job(1, 1, 1, -1, 0, -1, lat, dones, fr, feeds);
    chk("j111_lat", lat, 4);
    chk("j111_res", fr, 3);
    chk("j111_feeds", feeds, 1);

    run_job(2, 2, 2, -1, 0, -1, lat, dones, fr, feeds);
    chk("j222_lat", lat, 10);
    chk("j222_res", fr, 6);
    chk("j222_feeds", feeds, 2);

    // Illegal dimensions.
    tick();
    n_dim = 2'd0; k_dim = 2'd1; m_dim = 2'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("err_n0", int'(err), 1);
    chk("err_n0_busy", int'(busy), 0);
    tick();
    chk("err_n0_pulse", int'(err), 0);
    n_dim = 2'd1; k_dim = 2'd3; m_dim = 2'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("err_k3", int'(err), 1);
    chk("err_k3_busy", int'(busy), 0);

    // Backpressure on beat (0,1): ready low for relative cycles 6..8.
    run_job(2, 1, 2, 6, 3, -1, lat, dones, fr, feeds);
    chk("bp_lat", lat, 12);
    chk("bp_res", fr, 5);
    chk("bp_dones", dones, 1);
`ifdef MATMUL_CTRL_PERF_EN
    chk("bp_stall_cnt", int'(stall_cnt), 3);
`endif

    // Start while busy (during DRAIN at relative cycle 4) is ignored.
    run_job(2, 2, 1, -1, 0, 4, lat, dones, fr, feeds);
    chk("busy_start_lat", lat, 7);
    chk("busy_start_res", fr, 5);
    chk("busy_start_feeds", feeds, 2);
    chk("busy_start_dones", dones, 1);

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
